// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control unit for a multicycle RV32I core that shares one memory port
// between instruction fetch and data access. Each instruction moves through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The opcode and funct3 fields are
// captured when the fetch completes, datapath enables are decoded from the
// state and the captured opcode, a SYSTEM instruction parks the unit in
// HALT, and every retired instruction bumps instret.
//
// Memory handshake:
//   mem_req is raised in FETCH and MEM and stays high until the access
//   completes. With MEM_LATENCY==0 an access completes in the first cycle
//   where mem_ready is high. With MEM_LATENCY==N>0 it completes in exactly
//   the N-th cycle of the access and mem_ready is ignored. mem_we is high
//   only in MEM for a store, so a write never leaks into a fetch.
//
// Ports:
//   clk, rst                synchronous active-high reset
//   mem_opcode/mem_funct3   fields of the fetched word, taken on fetch done
//   mem_ready               access complete (MEM_LATENCY==0 only)
//   branch_taken            comparator result, used in EXEC of a branch
//   mem_req/mem_we          memory request / write strobe
//   mem_addr_sel            0=PC, 1=ALU result
//   ir_load/pc_write        instruction register capture / PC update pulses
//   pc_sel                  00=PC+4, 01=PC+imm, 10=(rs1+imm)&~1
//   alu_op/alu_src/auipc_sel ALU controls (valid in EXEC, held in MEM)
//   reg_write/wb_sel        register file write enable / write-back source
//   funct3_q                captured funct3
//   halted                  high while parked after SYSTEM
//   instret                 retired instruction count (wraps)
//   dbg_state               current FSM state for observation
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int MEM_LATENCY = 0,
  parameter int LAT_W       = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       mem_opcode,
  input  logic [2:0]       mem_funct3,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             auipc_sel,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [2:0]       funct3_q,
  output logic             halted,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [4:0] OP_LOAD    = 5'b00000;
  localparam logic [4:0] OP_STORE   = 5'b01000;
  localparam logic [4:0] OP_ARITH_I = 5'b00100;
  localparam logic [4:0] OP_ARITH_R = 5'b01100;
  localparam logic [4:0] OP_AUIPC   = 5'b00101;
  localparam logic [4:0] OP_LUI     = 5'b01101;
  localparam logic [4:0] OP_BRANCH  = 5'b11000;
  localparam logic [4:0] OP_JAL     = 5'b11011;
  localparam logic [4:0] OP_JALR    = 5'b11001;
  localparam logic [4:0] OP_SYSTEM  = 5'b11100;

  // Last counter value of a fixed-latency access.
  localparam logic [LAT_W-1:0] LAT_LAST =
    LAT_W'((MEM_LATENCY == 0) ? 0 : MEM_LATENCY - 1);

  state_t           r_state;
  logic [4:0]       r_opcode;
  logic [2:0]       r_funct3;
  logic [LAT_W-1:0] r_lat_cnt;
  logic [CNT_W-1:0] r_instret;

  logic w_done;
  logic w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr;
  logic w_is_auipc, w_is_system, w_known;
  logic [1:0] w_alu_op;
  logic       w_alu_src;

  assign w_done = (MEM_LATENCY == 0) ? mem_ready : (r_lat_cnt == LAT_LAST);

  assign w_is_load   = (r_opcode == OP_LOAD);
  assign w_is_store  = (r_opcode == OP_STORE);
  assign w_is_branch = (r_opcode == OP_BRANCH);
  assign w_is_jal    = (r_opcode == OP_JAL);
  assign w_is_jalr   = (r_opcode == OP_JALR);
  assign w_is_auipc  = (r_opcode == OP_AUIPC);
  assign w_is_system = (r_opcode == OP_SYSTEM);

  // Opcodes that go on to EXEC; anything else unknown retires as a NOP.
  assign w_known = w_is_load | w_is_store | w_is_branch | w_is_jal |
                   w_is_jalr | w_is_auipc | (r_opcode == OP_ARITH_I) |
                   (r_opcode == OP_ARITH_R) | (r_opcode == OP_LUI);

  // ALU control per opcode; shared by EXEC and MEM so the address computed
  // in EXEC stays stable for the whole memory access.
  always_comb begin
    w_alu_op  = 2'b00;
    w_alu_src = 1'b0;
    case (r_opcode)
      OP_LOAD, OP_STORE, OP_JALR, OP_AUIPC: begin
        w_alu_op  = 2'b00;
        w_alu_src = 1'b1;
      end
      OP_BRANCH: begin
        w_alu_op  = 2'b01;
        w_alu_src = 1'b0;
      end
      OP_ARITH_I, OP_LUI: begin
        w_alu_op  = 2'b10;
        w_alu_src = 1'b1;
      end
      OP_ARITH_R: begin
        w_alu_op  = 2'b10;
        w_alu_src = 1'b0;
      end
      default: begin
        w_alu_op  = 2'b00;
        w_alu_src = 1'b0;
      end
    endcase
  end

  // Output decode. Everything is held at zero while rst is high so the
  // reset cycle never issues a request or a write.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = 2'b00;
    alu_op       = 2'b00;
    alu_src      = 1'b0;
    auipc_sel    = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;
    halted       = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_load = w_done;
        end
        S_DECODE: begin
          if (!w_is_system && !w_known) pc_write = 1'b1;
        end
        S_EXEC: begin
          alu_op    = w_alu_op;
          alu_src   = w_alu_src;
          auipc_sel = w_is_auipc;
          if (w_is_branch) begin
            pc_write = 1'b1;
            pc_sel   = branch_taken ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = w_is_store;
          alu_op       = w_alu_op;
          alu_src      = w_alu_src;
          auipc_sel    = w_is_auipc;
          if (w_is_store && w_done) pc_write = 1'b1;
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          if (w_is_load)                  wb_sel = 2'b01;
          else if (w_is_jal || w_is_jalr) wb_sel = 2'b10;
          if (w_is_jal)       pc_sel = 2'b01;
          else if (w_is_jalr) pc_sel = 2'b10;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_opcode  <= '0;
      r_funct3  <= '0;
      r_lat_cnt <= '0;
      r_instret <= '0;
    end else begin
      // Every instruction retires in exactly the cycle that updates the PC.
      if (pc_write) r_instret <= r_instret + CNT_W'(1);

      if ((MEM_LATENCY != 0) && !w_done &&
          (r_state == S_FETCH || r_state == S_MEM))
        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
      else
        r_lat_cnt <= '0;

      case (r_state)
        S_FETCH: begin
          if (w_done) begin
            r_opcode <= mem_opcode;
            r_funct3 <= mem_funct3;
            r_state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_is_system)  r_state <= S_HALT;
          else if (w_known) r_state <= S_EXEC;
          else              r_state <= S_FETCH;
        end
        S_EXEC: begin
          if (w_is_branch)                  r_state <= S_FETCH;
          else if (w_is_load || w_is_store) r_state <= S_MEM;
          else                              r_state <= S_WB;
        end
        S_MEM: begin
          if (w_done) r_state <= w_is_load ? S_WB : S_FETCH;
        end
        S_WB:    r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign funct3_q  = r_funct3;
  assign instret   = r_instret;
  assign dbg_state = r_state;

endmodule
